// File: rtl/cpu_step_ctrl_if.sv
// Handshake bundle between the step controller and its surroundings:
// raw mode/button/tick inputs in, CPU enable and status out.
interface cpu_step_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             tick_in;
    logic             run_sw;
    logic             step_btn;
    logic             halt;
    logic             cpu_en;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] step_count;

    // Environment side: drives the raw controls, observes the enable.
    modport master (
        output tick_in, run_sw, step_btn, halt,
        input  cpu_en, state_o, step_count
    );

    // Controller side.
    modport slave (
        input  tick_in, run_sw, step_btn, halt,
        output cpu_en, state_o, step_count
    );
endinterface

// File: rtl/cpu_step_ctrl.sv
// CPU step controller: turns the divider's slow square wave into
// single-cycle CPU enable pulses, either free-running (one per slow
// rising edge) or single-stepped from a debounced push button.
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 16
) (
    input logic           clk,
    input logic           rst_n,
    cpu_step_ctrl_if.slave bus
);
    // Counter only ever needs to reach DEBOUNCE_CYCLES-1.
    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_STEP  = 2'd0,
        S_RUN   = 2'd1,
        S_ARMED = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    logic            tick_s1, tick_s2, tick_d;
    logic            run_s1, run_s2;
    logic            btn_s1, btn_s2;
    logic [DB_W-1:0] db_cnt;
    logic            btn_stable, btn_stable_d;
    logic            tick_rise, press;
    state_t          state;
    logic            cpu_en_q;
    logic [CNT_W-1:0] step_cnt;

    // Two-flop synchronizers plus the tick edge-detect delay.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_s1 <= 1'b0;
            tick_s2 <= 1'b0;
            tick_d  <= 1'b0;
            run_s1  <= 1'b0;
            run_s2  <= 1'b0;
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
        end else begin
            tick_s1 <= bus.tick_in;
            tick_s2 <= tick_s1;
            tick_d  <= tick_s2;
            run_s1  <= bus.run_sw;
            run_s2  <= run_s1;
            btn_s1  <= bus.step_btn;
            btn_s2  <= btn_s1;
        end
    end

    assign tick_rise = tick_s2 & ~tick_d;

    // Debounce: accept a new button level only after it has differed
    // from the stable level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_cnt       <= '0;
            btn_stable   <= 1'b0;
            btn_stable_d <= 1'b0;
        end else begin
            btn_stable_d <= btn_stable;
            if (btn_s2 == btn_stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_stable <= btn_s2;
                db_cnt     <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Only the press edge is an event; release is ignored.
    assign press = btn_stable & ~btn_stable_d;

    // Step FSM with registered enable and issued-step counter; halt
    // overrides every state rule, including a coincident tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_STEP;
            cpu_en_q <= 1'b0;
            step_cnt <= '0;
        end else begin
            cpu_en_q <= 1'b0;
            if (bus.halt) begin
                state <= S_HALT;
            end else begin
                case (state)
                    S_STEP: begin
                        if (run_s2)     state <= S_RUN;
                        else if (press) state <= S_ARMED;
                    end
                    S_ARMED: begin
                        if (tick_rise) begin
                            cpu_en_q <= 1'b1;
                            step_cnt <= step_cnt + CNT_W'(1);
                            state    <= S_STEP;
                        end else if (run_s2) begin
                            // Armed step is absorbed by the switch to run.
                            state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (tick_rise) begin
                            cpu_en_q <= 1'b1;
                            step_cnt <= step_cnt + CNT_W'(1);
                        end
                        if (!run_s2) state <= S_STEP;
                    end
                    S_HALT: begin
                        // The releasing press only leaves halt; it does not arm.
                        if (press) state <= S_STEP;
                    end
                    default: state <= S_STEP;
                endcase
            end
        end
    end

    assign bus.cpu_en     = cpu_en_q;
    assign bus.state_o    = state;
    assign bus.step_count = step_cnt;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DEBOUNCE_CYCLES=4, CNT_W=4 and a
// 20-cycle tick period. Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point.
module tb_cpu_step_ctrl;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int CNT_W           = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   pulses, lat;

    cpu_step_ctrl_if #(.CNT_W(CNT_W)) bus();

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic run);
        rst_n        = 1'b0;
        bus.tick_in  = 1'b0;
        bus.step_btn = 1'b0;
        bus.halt     = 1'b0;
        bus.run_sw   = run;
        step(3);
        rst_n = 1'b1;
    endtask

    // One full tick period: high 10 edges, low 10 edges. Reports the number
    // of cycles cpu_en was seen high and the edge index of the first one.
    task automatic run_tick(output int p, output int l);
        p = 0;
        l = -1;
        bus.tick_in = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (bus.cpu_en === 1'b1) begin
                p++;
                if (l < 0) l = k;
            end
            if (k == 10) bus.tick_in = 1'b0;
        end
    endtask

    initial begin
        // 1. Reset with tick toggling and run_sw high.
        bus.tick_in  = 1'b0;
        bus.run_sw   = 1'b1;
        bus.step_btn = 1'b0;
        bus.halt     = 1'b0;
        rst_n        = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("rst_cpu_en", 32'(bus.cpu_en), 0);
            check("rst_count", 32'(bus.step_count), 0);
            check("rst_state", 32'(bus.state_o), 0);
            bus.tick_in = ~bus.tick_in;
        end
        bus.tick_in = 1'b0;
        rst_n = 1'b1;
        step(3);
        check("rst_to_run", 32'(bus.state_o), 1);

        // 2. Free run for 10 tick periods.
        for (int i = 0; i < 10; i++) begin
            run_tick(pulses, lat);
            check("run_pulses", 32'(pulses), 1);
            check("run_latency", 32'(lat), 3);
        end
        check("run_count", 32'(bus.step_count), 10);

        // 3. Single step with a bouncy button.
        do_reset(1'b0);
        step(3);
        check("ss_idle", 32'(bus.state_o), 0);
        for (int i = 0; i < 10; i++) begin
            bus.step_btn = ((i / 2) % 2 == 1);
            step(1);
        end
        check("ss_glitch_nopress", 32'(bus.state_o), 0);
        bus.step_btn = 1'b1;
        step(8);
        check("ss_armed", 32'(bus.state_o), 2);
        run_tick(pulses, lat);
        check("ss_pulses", 32'(pulses), 1);
        check("ss_latency", 32'(lat), 3);
        check("ss_back_step", 32'(bus.state_o), 0);
        check("ss_count", 32'(bus.step_count), 1);
        bus.step_btn = 1'b0;
        step(8);
        check("ss_release_noevent", 32'(bus.state_o), 0);

        // 4. Halt coincident with a tick in run mode.
        do_reset(1'b1);
        step(3);
        check("halt_pre_run", 32'(bus.state_o), 1);
        bus.tick_in = 1'b1;
        step(2);
        bus.halt = 1'b1;
        step(1);
        check("halt_tick_en", 32'(bus.cpu_en), 0);
        check("halt_state", 32'(bus.state_o), 3);
        step(1);
        check("halt_tick_en_next", 32'(bus.cpu_en), 0);
        step(7);
        bus.tick_in = 1'b0;
        step(10);
        for (int i = 0; i < 2; i++) begin
            run_tick(pulses, lat);
            check("halt_no_pulses", 32'(pulses), 0);
        end
        bus.run_sw = 1'b0;
        bus.halt   = 1'b0;
        step(5);
        check("halt_holds", 32'(bus.state_o), 3);
        bus.step_btn = 1'b1;
        step(8);
        check("halt_exit", 32'(bus.state_o), 0);
        check("halt_count", 32'(bus.step_count), 0);
        bus.step_btn = 1'b0;
        step(8);
        check("halt_exit_noarm", 32'(bus.state_o), 0);

        // 5A. Switch to run while armed.
        do_reset(1'b0);
        step(3);
        bus.step_btn = 1'b1;
        step(8);
        check("race_armed", 32'(bus.state_o), 2);
        bus.step_btn = 1'b0;
        bus.run_sw   = 1'b1;
        step(3);
        check("race_a_state", 32'(bus.state_o), 1);
        check("race_a_absorbed", 32'(bus.step_count), 0);
        for (int i = 0; i < 3; i++) begin
            run_tick(pulses, lat);
            check("race_a_pulses", 32'(pulses), 1);
        end
        check("race_a_count", 32'(bus.step_count), 3);

        // 5B. run_s2 falls in the tick_rise cycle.
        bus.run_sw = 1'b0;
        run_tick(pulses, lat);
        check("race_b_pulses", 32'(pulses), 1);
        check("race_b_latency", 32'(lat), 3);
        check("race_b_state", 32'(bus.state_o), 0);
        check("race_b_count", 32'(bus.step_count), 4);

        // 6. Counter wrap at 4 bits.
        do_reset(1'b1);
        step(3);
        for (int i = 1; i <= 17; i++) begin
            run_tick(pulses, lat);
            if (i >= 15) check("wrap_count", 32'(bus.step_count), 32'(i % 16));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
- Sits directly downstream of the slow-clock divider.
- Consumes the divider's slow square wave as a data signal in the fast clock domain and generates single-cycle CPU clock-enable pulses.
- Supports free-run mode (one pulse per slow-clock rising edge) and single-step mode (one pulse per debounced push-button press, aligned to the next slow tick).
- A CPU halt request freezes stepping.

Parameters:
DEBOUNCE_CYCLES, 500000, number of consecutive clk cycles a synchronized button level must differ from the stable level before it is accepted
CNT_W, 16, width of the issued-step counter

Ports:
clk  input  1  system clock, the same fast clock that drives the divider
rst_n  input  1  reset; synchronous and active-low, sampled on rising clk
tick_in  input  1  slow square wave from the divider; asynchronous to this logic's sampling
run_sw  input  1  mode switch; 1 = free-run, 0 = single-step; raw level
step_btn  input  1  raw push button, active-high, bouncy
halt  input  1  halt request from the CPU, synchronous to clk, level
cpu_en  output  1  one-clk-cycle CPU enable pulse, registered
state_o  output  2  current FSM state encoding
step_count  output  CNT_W  number of cpu_en pulses issued since reset

Behaviour:
- Reset (rst_n=0 at a rising clk edge):
  - All synchronizers, the edge-detect flop, debounce counter and btn_stable go to 0.
  - FSM goes to S_STEP; cpu_en=0, step_count=0, state_o=2'd0.
  - Reset mid-operation discards any armed step and any in-progress debounce.
- Synchronization:
  - tick_in, run_sw and step_btn each pass through 2 flops.
  - halt is used directly.
- Tick edge:
  - tick_rise = tick_s2 & ~tick_d, where tick_d is tick_s2 delayed one cycle.
  - Exactly one clk cycle per slow rising edge.
- Debounce:
  - If btn_s2 == btn_stable, the counter clears to 0.
  - Otherwise the counter increments. When the counter == DEBOUNCE_CYCLES-1 and the levels still differ, btn_stable <= btn_s2 and the counter clears.
  - press = one-cycle pulse on the 0->1 transition of btn_stable. Release produces no event.
  - The counter width must hold DEBOUNCE_CYCLES-1.
- FSM states: S_STEP=0, S_RUN=1, S_ARMED=2, S_HALT=3. Priority order: halt, then state rules.
  - Any state, halt=1: next state S_HALT. cpu_en stays 0 that cycle even if tick_rise=1.
  - S_STEP:
    - run_s2=1 -> S_RUN.
    - Else press -> S_ARMED.
  - S_ARMED:
    - tick_rise -> cpu_en pulse, then S_STEP.
    - Else run_s2=1 -> S_RUN; the armed step is absorbed with no extra pulse.
    - Additional presses are ignored.
  - S_RUN:
    - Each tick_rise produces a cpu_en pulse.
    - run_s2=0 -> S_STEP. If tick_rise occurs in the same cycle, the pulse is still issued.
  - S_HALT:
    - No pulses.
    - halt=0 and press -> S_STEP. The releasing press does not itself arm a step.
- cpu_en timing:
  - Registered: high during the cycle after the deciding cycle, for exactly 1 cycle.
  - Latency from the first clk edge sampling tick_in=1 to cpu_en high is 3 clk edges (sync1, sync2, output register).
  - Never high in two consecutive cycles.
- step_count:
  - Increments by 1 in the cycle cpu_en is registered high, becoming visible with cpu_en.
  - Wraps from 2^CNT_W-1 to 0 silently.
- state_o is the registered state.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=4, tick_in period 20 clk):
1. Reset:
   - Stimulus: hold rst_n=0 for 3 edges with tick_in toggling and run_sw=1.
   - Required: cpu_en=0, step_count=0, state_o=0 throughout; after release, state_o=1 within 3 cycles.
2. Free-run:
   - Stimulus: run_sw=1 for 10 tick_in periods.
   - Required: exactly 10 single-cycle cpu_en pulses, each 3 edges after the tick_in rise; step_count=10.
3. Single-step with bounce:
   - Stimulus: run_sw=0; step_btn toggles every 2 cycles for 10 cycles, then holds 1 for 8 cycles.
   - Required: exactly one press; state_o=2; one cpu_en at the next tick; state_o returns to 0; step_count=1. Glitches shorter than 4 cycles produce no press.
4. Halt priority:
   - Stimulus: in S_RUN, assert halt in the same cycle tick_rise occurs.
   - Required: no cpu_en; state_o=3; further ticks give no pulses. Then halt=0 plus a debounced press -> state_o=0 and step_count unchanged.
5. Mode change races:
   - Stimulus A: in S_ARMED, set run_sw=1 before the tick.
   - Required A: state_o=1 and only one pulse per subsequent tick.
   - Stimulus B: in S_RUN, drop run_sw so that run_s2 falls in the tick_rise cycle.
   - Required B: that pulse is issued, then state_o=0.
6. Counter wrap:
   - Stimulus: free-run 17 ticks with CNT_W=4.
   - Required: step_count reaches 15, then 0, then 1.
